fifo_rd_framer: RTL
===================

// Module: fifo_rd_framer
// PURPOSE
//  Read-side consumer of the 8x16 asynchronous FIFO. Pops 16-bit words in the
//  FIFO read clock domain, parses packet headers, and presents a framed stream
//  (sop/eop) to downstream logic with stall back-pressure. Over-length packets
//  are discarded, flagged and counted.
// PARAMETERS
//  MAX_LEN  32  largest legal payload length in words (1..255)
//  CNT_W    16  width of the accepted/dropped packet counters
// PORTS
//  clk          in   1      FIFO read-domain clock; all logic clocked on posedge
//  rst_n        in   1      asynchronous, active-low reset
//  i_fifo_data  in   16     FIFO head word; valid whenever i_fifo_empty=0
//  i_fifo_empty in   1      FIFO empty
//  o_fifo_rd_en out  1      pop head word this cycle (only when i_fifo_empty=0)
//  o_data       out  16     output word (header or payload)
//  o_valid      out  1      o_data valid
//  o_sop        out  1      o_data is the header word
//  o_eop        out  1      o_data is the last word of the packet
//  i_stall      in   1      downstream cannot accept; transfer = o_valid & ~i_stall
//  o_err        out  1      sticky: over-length packet seen
//  i_err_clr    in   1      clears o_err (loses to a same-cycle new error)
//  o_pkt_cnt    out  CNT_W  packets delivered (counted at eop transfer), wraps
//  o_drop_cnt   out  CNT_W  packets dropped (counted at header pop), wraps
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=HDR; o_valid, o_sop, o_eop, o_err,
//    o_fifo_rd_en = 0; o_data = 0; both counters = 0; word counter = 0.
//  - Header word: bits [7:0] = payload length L; bits [15:8] are passed through.
//  - FIFO is first-word-fall-through: a word is consumed in the cycle
//    o_fifo_rd_en=1. It is registered into o_data at that edge, so latency is
//    1 cycle from pop to o_valid.
//  - Pop rule in HDR/BODY: o_fifo_rd_en = ~i_fifo_empty & (~o_valid | ~i_stall).
//    The output register is single-entry: it is reloaded on the same edge it
//    transfers, sustaining 1 word/cycle. The rule is combinational from i_stall.
//  - o_data, o_sop and o_eop are held stable while o_valid & i_stall.
//    o_valid drops after a transfer when no pop occurs in the same cycle.
//  - States:
//     HDR : on pop, if L > MAX_LEN: do not emit, set o_err, drop_cnt+1,
//           cnt<=L, ->DROP (L>MAX_LEN is always >=1). Else emit with o_sop=1;
//           if L==0: o_eop=1, stay HDR; else cnt<=L, ->BODY.
//     BODY: on pop, emit with o_sop=0, cnt-1; if cnt==1: o_eop=1, ->HDR.
//     DROP: o_fifo_rd_en = ~i_fifo_empty, independent of i_stall; nothing
//           emitted; cnt-1 per pop; at cnt==1 pop ->HDR. A valid word already
//           in the output register still completes normally.
//  - cnt is 8 bits and never underflows. An empty FIFO mid-packet simply waits;
//    there is no timeout.
//  - pkt_cnt increments on a transfer with o_eop=1. Counters wrap at 2^CNT_W.
//  - Reset mid-packet abandons the packet; the next word popped is treated
//    as a header.
// STRUCTURE
//  - Header field positions (LEN_LSB=0, LEN_MSB=7) and state encodings go in
//    the shared packet-format include, used by the write-side packetizer too.
//  - Flat module, no sub-modules: 3-state FSM, output register, 8-bit word
//    counter, two event counters.
// TESTING
//  1 Hdr L=3 + 3 words, i_stall=0 -> 4 consecutive valids, sop on word 0,
//    eop on word 3, pkt_cnt=1.
//  2 Hdr L=0 -> one valid word with sop=1, eop=1; FSM stays HDR.
//  3 Hdr L=40 (MAX_LEN=32) + 40 words, then hdr L=1 + 1 word -> the 41 words
//    are popped with no valid; o_err=1, drop_cnt=1; the next packet is emitted
//    intact.
//  4 Hold i_stall=1 for 5 cycles mid-packet -> o_data stable, no pops; data
//    resumes in order, none lost or duplicated.
//  5 FIFO goes empty between payload words 1 and 2 -> o_valid=0 gap, FSM holds
//    BODY, eop still lands on the correct word.
//  6 rst_n pulsed low in BODY -> all outputs 0 asynchronously; the first
//    post-reset pop is parsed as a header.

Source files
------------

// File: rtl/fifo_rd_framer_pkg.sv
// Shared packet-format definitions: header field positions and framer state encoding.
package fifo_rd_framer_pkg;

   localparam int WORD_W  = 16;
   localparam int LEN_LSB = 0;
   localparam int LEN_MSB = 7;
   localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_BODY = 2'd1,
      ST_DROP = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_rd_framer.sv
// Read-side FIFO consumer: parses headers, emits a sop/eop framed stream with
// stall back-pressure, and discards/counts over-length packets.
//
//   state | meaning
//   HDR   | next popped word is a header
//   BODY  | forwarding payload words, r_cnt words remain
//   DROP  | discarding payload of an over-length packet, r_cnt words remain
module fifo_rd_framer
   import fifo_rd_framer_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int CNT_W   = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] i_fifo_data,
   input  logic              i_fifo_empty,
   output logic              o_fifo_rd_en,
   output logic [WORD_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_sop,
   output logic              o_eop,
   input  logic              i_stall,
   output logic              o_err,
   input  logic              i_err_clr,
   output logic [CNT_W-1:0]  o_pkt_cnt,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_cnt;
   logic [LEN_W-1:0]    w_cnt_nxt;
   logic [WORD_W-1:0]   r_data;
   logic                r_valid;
   logic                r_sop;
   logic                r_eop;
   logic                r_err;
   logic [CNT_W-1:0]    r_pkt_cnt;
   logic [CNT_W-1:0]    r_drop_cnt;

   logic [LEN_W-1:0]    w_len;
   logic                w_xfer;
   logic                w_pop;
   logic                w_emit;
   logic                w_emit_sop;
   logic                w_emit_eop;
   logic                w_drop_hdr;

   assign w_len  = i_fifo_data[LEN_MSB:LEN_LSB];
   assign w_xfer = r_valid & ~i_stall;

   // Next-state, pop and emit decode; output register reloads on the same edge it transfers
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      w_emit      = 1'b0;
      w_emit_sop  = 1'b0;
      w_emit_eop  = 1'b0;
      w_drop_hdr  = 1'b0;
      case (r_state)
         ST_HDR: begin
            w_pop = ~i_fifo_empty & (~r_valid | ~i_stall);
            if (w_pop) begin
               if (w_len > MAX_LEN_V) begin
                  w_drop_hdr  = 1'b1;
                  w_cnt_nxt   = w_len;
                  w_state_nxt = ST_DROP;
               end else begin
                  w_emit     = 1'b1;
                  w_emit_sop = 1'b1;
                  if (w_len == '0) begin
                     w_emit_eop = 1'b1;
                  end else begin
                     w_cnt_nxt   = w_len;
                     w_state_nxt = ST_BODY;
                  end
               end
            end
         end
         ST_BODY: begin
            w_pop = ~i_fifo_empty & (~r_valid | ~i_stall);
            if (w_pop) begin
               w_emit    = 1'b1;
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt == LEN_W'(1)) begin
                  w_emit_eop  = 1'b1;
                  w_state_nxt = ST_HDR;
               end
            end
         end
         ST_DROP: begin
            // Discarded words never touch the output register, so stall is irrelevant
            w_pop = ~i_fifo_empty;
            if (w_pop) begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt == LEN_W'(1)) begin
                  w_state_nxt = ST_HDR;
               end
            end
         end
         default: begin
            w_state_nxt = ST_HDR;
         end
      endcase
   end

   // Pop strobe is forced low while reset is asserted
   assign o_fifo_rd_en = w_pop & rst_n;

   // FSM state and word counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HDR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Single-entry output register, held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
      end else if (w_emit) begin
         r_data  <= i_fifo_data;
         r_valid <= 1'b1;
         r_sop   <= w_emit_sop;
         r_eop   <= w_emit_eop;
      end else if (w_xfer) begin
         r_valid <= 1'b0;
      end
   end

   // Sticky error (set wins over clear) and wrapping event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err      <= 1'b0;
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_drop_hdr) begin
            r_err <= 1'b1;
         end else if (i_err_clr) begin
            r_err <= 1'b0;
         end
         if (w_xfer & r_eop) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
         end
         if (w_drop_hdr) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign o_data     = r_data;
   assign o_valid    = r_valid;
   assign o_sop      = r_sop;
   assign o_eop      = r_eop;
   assign o_err      = r_err;
   assign o_pkt_cnt  = r_pkt_cnt;
   assign o_drop_cnt = r_drop_cnt;

endmodule
